// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: saturating cycle/event counters, a cycle budget
// FSM (IDLE/RUN/DONE), sticky overflow flags and an atomic snapshot readout bank.
module pipe_perf_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int LIMIT_W = 16,
  localparam int SEL_W  = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  localparam int NCH = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             done_r;
  logic [CNT_W-1:0] cnt_r     [NCH];
  logic [CNT_W-1:0] cnt_nxt_s [NCH];
  logic [CNT_W-1:0] shadow_r  [NCH];
  logic [NCH-1:0]   ovf_r, ovf_nxt_s, inc_s;
  logic [CNT_W-1:0] limit_s;
  logic             counting_s, limit_hit_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
  endfunction

  // Channel 0 is the cycle counter and increments on every counting edge.
  assign counting_s  = (state_r == ST_RUN) && start_i && !clear_i;
  assign inc_s       = counting_s ? {evt_i, 1'b1} : {NCH{1'b0}};
  assign limit_s     = CNT_W'(limit_i);
  assign limit_hit_s = (limit_i != {LIMIT_W{1'b0}}) && (cnt_nxt_s[0] == limit_s);

  // Saturating next-count and sticky overflow for every channel.
  always_comb begin
    ovf_nxt_s = ovf_r;
    for (int k = 0; k < NCH; k++) begin
      cnt_nxt_s[k] = cnt_r[k];
      if (inc_s[k]) begin
        cnt_nxt_s[k] = sat_inc(cnt_r[k]);
        ovf_nxt_s[k] = ovf_r[k] | (cnt_r[k] == CNT_MAX);
      end else begin
        cnt_nxt_s[k] = cnt_r[k];
      end
    end
  end

  // Next-state logic; clear wins over everything and DONE is left only by clear.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) state_nxt_s = ST_RUN;
          else         state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (!start_i)        state_nxt_s = ST_IDLE;
          else if (limit_hit_s) state_nxt_s = ST_DONE;
          else                 state_nxt_s = ST_RUN;
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, done flag and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      ovf_r   <= {NCH{1'b0}};
    end else if (clear_i) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      ovf_r   <= {NCH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Live counters and shadow bank; a snapshot captures the post-update values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_r[k]    <= CNT_ZERO;
        shadow_r[k] <= CNT_ZERO;
      end
    end else if (clear_i) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_r[k]    <= CNT_ZERO;
        shadow_r[k] <= CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
        if (snap_i) shadow_r[k] <= cnt_nxt_s[k];
        else        shadow_r[k] <= shadow_r[k];
      end
    end
  end

  // Combinational readout; out-of-range selects return zero.
  always_comb begin
    rd_data_o = CNT_ZERO;
    if (rd_sel_i <= SEL_W'(NUM_EVT)) rd_data_o = shadow_r[rd_sel_i];
    else                             rd_data_o = CNT_ZERO;
  end

  assign ovf_o   = ovf_r;
  assign done_o  = done_r;
  assign state_o = state_r;

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Parametrised, synthesizable pipeline performance monitor for the CPU. Counts elapsed run cycles and up to NUM_EVT per-cycle event pulses (stall, flush, branch-taken, jump, ...) and stops itself after a programmable cycle budget. Counters saturate and latch overflow flags. An atomic snapshot register bank feeds a muxed readout port. It sits beside the CPU top-level, with event inputs tapped from the hazard-detection and control units and start_i shared with the CPU.

## Interface
- NUM_EVT, 4: number of event channels (1..15).
- CNT_W, 32: width of every counter and of rd_data_o (4..32).
- LIMIT_W, 16: width of the cycle-budget input.
- SEL_W, $clog2(NUM_EVT+1): readout select width (derived, do not override).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  run enable; level-sensitive.
- clear_i  in  1  synchronous clear of counters, shadows, flags and state.
- evt_i  in  NUM_EVT  event pulses; bit k counted once per run edge where high.
- limit_i  in  LIMIT_W  cycle budget; 0 = unlimited.
- snap_i  in  1  copy live counters into shadow bank.
- rd_sel_i  in  SEL_W  readout select: 0 = cycle counter, k = event k-1.
- rd_data_o  out  CNT_W  shadow value selected by rd_sel_i.
- ovf_o  out  NUM_EVT+1  sticky saturation flags: bit 0 = cycle counter, bit k = event k-1.
- done_o  out  1  high while in DONE.
- state_o  out  2  00 IDLE, 01 RUN, 10 DONE.

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: counters hold. An edge sampling start_i=1 moves to RUN; that edge does not count.
- RUN: every edge does cycle_cnt += 1 and evt_cnt[k] += evt_i[k]. An edge sampling start_i=0 moves to IDLE and does not count (pause, counts retained).
- Budget: when limit_i != 0 and the post-update cycle_cnt == limit_i (zero-extended or truncated to CNT_W), the same edge moves to DONE. limit_i is sampled every edge. If the count is already past a newly lowered limit, run continues until saturation; there is no wrap-match.
- DONE: all counters frozen. start_i is ignored. The state is left only via clear_i or reset.
- Saturation: a counter at all-ones stays all-ones and never wraps. Its ovf_o bit sets on the edge where an increment is attempted at all-ones, and stays set until clear_i or reset.
- clear_i has priority over all other synchronous inputs. It zeroes live counters, shadows and ovf_o, and forces IDLE. Counting and FSM transitions are suppressed on that edge.
- Snapshot: on an edge with snap_i=1, every shadow loads its live counter's post-update value (the value visible in the live register after that edge). All channels load on the same edge.
- clear_i and snap_i on the same edge: shadows load 0.
- rd_data_o is combinational from the shadow bank. For rd_sel_i > NUM_EVT, rd_data_o = 0.
- Unused limit: limit_i = 0 never triggers DONE, including on the first edge.

## Timing
- Reset (rst_n_i low) takes effect immediately with no clock required: live counters, shadows, ovf_o all 0; rd_data_o = 0; done_o = 0; state_o = 00.
- Reset asserted mid-run takes effect immediately. Release is synchronised by the integrator; the block needs no edge after release before accepting start_i.
- Event latency: an evt_i pulse sampled on edge N is in the live counter after edge N. It is visible on rd_data_o after a snap on edge N or later.
- done_o rises after the edge producing the limit-th count, i.e. exactly limit_i counting edges after entering RUN (with no pauses).
- ovf_o and state_o are registered. rd_data_o has zero-cycle latency from rd_sel_i.

## Test plan
- Reset, start_i=1 held, evt_i=0, limit_i=0; snap on the 11th edge after start -> rd_sel 0 reads 10, all events 0, state_o=01.
- NUM_EVT=2, limit_i=30, evt_i[0] high every 3rd counting cycle, evt_i[1] high once -> done_o rises after the 30th counting edge; reads cycle=30, evt0=10, evt1=1; 5 further edges change nothing.
- CNT_W=4, evt_i[0]=1 constant for 20 counting edges -> cycle=15, evt0=15, ovf_o=3'b011; ovf_o stays set after start_i drops.
- Run 8 edges, start_i=0 for 5 edges with evt_i=all-ones, resume 4 edges -> cycle=12; events count only while in RUN; state_o=00 during the pause.
- In DONE, assert clear_i and snap_i together -> shadows 0, ovf_o 0, state_o=00, done_o=0 on the next cycle; rd_sel_i=NUM_EVT+1 reads 0.
- Drop rst_n_i mid-run between clock edges -> all outputs 0 and state_o=00 before the next edge.
